tl2reg_bridge: RTL

Parametrised TileLink-UL device-side bridge from one TL-UL A/D channel pair onto a simple register-file strobe interface. Next-generation register adapter: configurable data width, register read latency and response-queue depth, so multiple requests can be in flight. Decodes and rejects malformed requests (opcode, alignment, size, mask) without strobing the register file. Sits between the crossbar device port and each peripheral's CSR block.

---
 rtl/tl2reg_bridge.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/tl2reg_bridge.sv
// TL-UL device-side bridge onto a register-file strobe interface.
// Malformed requests are answered with a denied AccessAck without touching the register file.
module tl2reg_bridge #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned SIZE_WIDTH   = 3,
   parameter int unsigned SOURCE_WIDTH = 8,
   parameter int unsigned RSP_DEPTH    = 2,
   parameter int unsigned READ_LATENCY = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                bridge_i_tl_a_opcode,
   input  logic [2:0]                bridge_i_tl_a_param,
   input  logic [SIZE_WIDTH-1:0]     bridge_i_tl_a_size,
   input  logic [SOURCE_WIDTH-1:0]   bridge_i_tl_a_source,
   input  logic [ADDR_WIDTH-1:0]     bridge_i_tl_a_address,
   input  logic [DATA_WIDTH/8-1:0]   bridge_i_tl_a_mask,
   input  logic [DATA_WIDTH-1:0]     bridge_i_tl_a_data,
   input  logic                      bridge_i_tl_a_corrupt,
   input  logic                      bridge_i_tl_a_valid,
   output logic                      bridge_o_tl_a_ready,
   output logic [2:0]                bridge_o_tl_d_opcode,
   output logic [1:0]                bridge_o_tl_d_param,
   output logic [SIZE_WIDTH-1:0]     bridge_o_tl_d_size,
   output logic [SOURCE_WIDTH-1:0]   bridge_o_tl_d_source,
   output logic                      bridge_o_tl_d_sink,
   output logic                      bridge_o_tl_d_denied,
   output logic [DATA_WIDTH-1:0]     bridge_o_tl_d_data,
   output logic                      bridge_o_tl_d_corrupt,
   output logic                      bridge_o_tl_d_valid,
   input  logic                      bridge_i_tl_d_ready,
   output logic [ADDR_WIDTH-1:0]     bridge_o_address,
   output logic                      bridge_o_r_en,
   output logic                      bridge_o_w_en,
   output logic [DATA_WIDTH/8-1:0]   bridge_o_wmask,
   output logic [DATA_WIDTH-1:0]     bridge_o_wdata,
   input  logic [DATA_WIDTH-1:0]     bridge_i_rdata,
   input  logic                      bridge_i_err
);
   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(MASK_W);
   localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;
   localparam logic [2:0] OP_ACK      = 3'd0;
   localparam logic [2:0] OP_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]              opcode;
      logic [SIZE_WIDTH-1:0]   size;
      logic [SOURCE_WIDTH-1:0] source;
      logic [DATA_WIDTH-1:0]   data;
      logic                    denied;
      logic                    corrupt;
   } rsp_t;

   typedef struct packed {
      logic                    is_get;
      logic                    err_int;
      logic [SIZE_WIDTH-1:0]   size;
      logic [SOURCE_WIDTH-1:0] source;
   } stg_t;

   logic [CNT_W-1:0]   r_occ;
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic               r_a_ready;
   logic               r_stg_valid;
   stg_t               r_stg;
   rsp_t               r_q [RSP_DEPTH];

   logic               w_is_get;
   logic               w_is_full;
   logic               w_is_put;
   logic               w_op_bad;
   logic               w_size_bad;
   logic               w_misaligned;
   logic               w_mask_bad;
   logic               w_err_int;
   logic [MASK_W-1:0]  w_lanes;
   int unsigned        w_off;
   int unsigned        w_nbytes;
   logic               w_a_fire;
   logic               w_push;
   logic               w_pop;
   rsp_t               w_push_rsp;
   rsp_t               w_head;
   logic               w_d_valid;
   logic [CNT_W-1:0]   w_occ_nxt;
   logic               w_stg_nxt;
   logic               w_ready_nxt;
   logic               w_unused;

   function automatic rsp_t mk_rsp(input logic is_get, input logic err_int,
                                   input logic [SIZE_WIDTH-1:0] size,
                                   input logic [SOURCE_WIDTH-1:0] source,
                                   input logic [DATA_WIDTH-1:0] rdata, input logic err);
      rsp_t r;
      r.opcode  = (is_get && !err_int) ? OP_ACK_DATA : OP_ACK;
      r.size    = size;
      r.source  = source;
      r.data    = err_int ? {(DATA_WIDTH/4){4'hE}} : (is_get ? rdata : '0);
      r.denied  = err_int | err;
      r.corrupt = r.denied && (r.opcode == OP_ACK_DATA);
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == RSP_DEPTH - 32'd1) ? '0 : PTR_W'(32'(p) + 32'd1);
   endfunction

   // Request legality: opcode, size, natural alignment and byte-lane mask
   always_comb begin
      w_is_get     = (bridge_i_tl_a_opcode == OP_GET);
      w_is_full    = (bridge_i_tl_a_opcode == OP_PUT_FULL);
      w_is_put     = w_is_full || (bridge_i_tl_a_opcode == OP_PUT_PART);
      w_op_bad     = !(w_is_get || w_is_put);
      w_size_bad   = bridge_i_tl_a_size > SIZE_WIDTH'(OFF_W);
      w_nbytes     = w_size_bad ? 32'd1 : (32'd1 << bridge_i_tl_a_size);
      w_off        = 32'(bridge_i_tl_a_address[OFF_W-1:0]);
      w_misaligned = (w_off & (w_nbytes - 32'd1)) != 32'd0;
      w_lanes      = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         w_lanes[i] = (i >= w_off) && (i < w_off + w_nbytes);
      end
      w_mask_bad   = (|(bridge_i_tl_a_mask & ~w_lanes)) ||
                     (w_is_full && (bridge_i_tl_a_mask != w_lanes));
      w_err_int    = w_op_bad | w_size_bad | w_misaligned | w_mask_bad | bridge_i_tl_a_corrupt;
   end

   assign w_a_fire         = bridge_i_tl_a_valid & r_a_ready;
   assign bridge_o_r_en    = w_a_fire & w_is_get & ~w_err_int;
   assign bridge_o_w_en    = w_a_fire & w_is_put & ~w_err_int;
   assign bridge_o_address = bridge_i_tl_a_address;
   assign bridge_o_wmask   = bridge_i_tl_a_mask;
   assign bridge_o_wdata   = bridge_i_tl_a_data;
   assign bridge_o_tl_a_ready = r_a_ready;

   // With one cycle of read latency the entry is built from the staged request
   always_comb begin
      if (READ_LATENCY == 0) begin
         w_push     = w_a_fire;
         w_push_rsp = mk_rsp(w_is_get, w_err_int, bridge_i_tl_a_size, bridge_i_tl_a_source,
                             bridge_i_rdata, bridge_i_err);
      end else begin
         w_push     = r_stg_valid;
         w_push_rsp = mk_rsp(r_stg.is_get, r_stg.err_int, r_stg.size, r_stg.source,
                             bridge_i_rdata, bridge_i_err);
      end
   end

   assign w_d_valid = (r_occ != '0);
   assign w_pop     = w_d_valid & bridge_i_tl_d_ready;
   assign w_head    = r_q[r_rptr];

   // a_ready is registered, so it reflects next-cycle occupancy without pop lookahead
   always_comb begin
      w_occ_nxt = r_occ;
      if (w_push && !w_pop) begin
         w_occ_nxt = r_occ + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_occ_nxt = r_occ - CNT_W'(1);
      end
      w_stg_nxt   = (READ_LATENCY != 0) && w_a_fire;
      w_ready_nxt = (32'(w_occ_nxt) + 32'(w_stg_nxt)) < RSP_DEPTH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ       <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_a_ready   <= 1'b0;
         r_stg_valid <= 1'b0;
         r_stg       <= '0;
      end else begin
         r_occ       <= w_occ_nxt;
         r_a_ready   <= w_ready_nxt;
         r_stg_valid <= w_stg_nxt;
         if (w_a_fire) begin
            r_stg.is_get  <= w_is_get;
            r_stg.err_int <= w_err_int;
            r_stg.size    <= bridge_i_tl_a_size;
            r_stg.source  <= bridge_i_tl_a_source;
         end
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_q[r_wptr] <= w_push_rsp;
   end

   assign bridge_o_tl_d_valid   = w_d_valid;
   assign bridge_o_tl_d_opcode  = w_d_valid ? w_head.opcode  : '0;
   assign bridge_o_tl_d_size    = w_d_valid ? w_head.size    : '0;
   assign bridge_o_tl_d_source  = w_d_valid ? w_head.source  : '0;
   assign bridge_o_tl_d_data    = w_d_valid ? w_head.data    : '0;
   assign bridge_o_tl_d_denied  = w_d_valid & w_head.denied;
   assign bridge_o_tl_d_corrupt = w_d_valid & w_head.corrupt;
   assign bridge_o_tl_d_param   = '0;
   assign bridge_o_tl_d_sink    = 1'b0;

   assign w_unused = ^bridge_i_tl_a_param;
endmodule
